// File: rtl/alu_control_md.sv
// MIPS ALU control decoder with an iterative multiply/divide unit owning HI/LO.
// Build option SIGNED_MD_EN adds signed MULT/DIV on the same iterative datapath.
module alu_control_md #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic             valid,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [3:0]       alu_control,
    output logic             illegal,
    output logic             stall,
    output logic             md_busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_DIV   = 6'b011010;

    typedef enum logic [1:0] {IDLE = 2'b00, MUL = 2'b01, DIV = 2'b10} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_a;
    logic [2*WIDTH-1:0]   r_prod;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_dz;

    logic                 w_is_mul;
    logic                 w_is_div;
    logic                 w_is_signed;
    logic                 w_md_class;
    logic                 w_start;
    logic                 w_dz_case;
    logic [WIDTH-1:0]     w_rs_mag;
    logic [WIDTH-1:0]     w_rt_mag;
    logic [WIDTH:0]       w_add;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_trial;
    logic [2*WIDTH-1:0]   w_prod_nxt;
    logic [2*WIDTH-1:0]   w_full;
    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;

`ifdef SIGNED_MD_EN
    assign w_is_mul    = (funct == F_MULTU) || (funct == F_MULT);
    assign w_is_div    = (funct == F_DIVU)  || (funct == F_DIV);
    assign w_is_signed = (funct == F_MULT)  || (funct == F_DIV);
`else
    assign w_is_mul    = (funct == F_MULTU);
    assign w_is_div    = (funct == F_DIVU);
    assign w_is_signed = 1'b0;
`endif

    assign w_md_class = (alu_op == 2'b10) &&
                        (w_is_mul || w_is_div || funct == F_MFHI || funct == F_MFLO);
    assign w_start    = valid && (r_state == IDLE) && (w_is_mul || w_is_div);
    assign w_dz_case  = w_is_div && (rt_val == {WIDTH{1'b0}});
    assign w_rs_mag   = (w_is_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign w_rt_mag   = (w_is_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    assign stall    = valid && w_md_class && (r_state != IDLE);
    assign md_busy  = (r_state != IDLE);
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_dz;

    // Combinational decode of alu_op/funct into the ALU control code
    always_comb begin
        alu_control = 4'b1111;
        illegal     = 1'b0;
        case (alu_op)
            2'b00: alu_control = 4'b0010;
            2'b01: begin
                if (funct == 6'b001000) alu_control = 4'b0011;
                else                    alu_control = 4'b0110;
            end
            2'b10: begin
                case (funct)
                    6'b100000: alu_control = 4'b0010;
                    6'b100010: alu_control = 4'b0110;
                    6'b100100: alu_control = 4'b0000;
                    6'b100101: alu_control = 4'b0001;
                    6'b101010: alu_control = 4'b0111;
                    6'b100111: alu_control = 4'b1000;
                    6'b100110: alu_control = 4'b1001;
                    6'b000000: alu_control = 4'b1010;
                    6'b000010: alu_control = 4'b1011;
                    6'b101011: alu_control = 4'b1100;
                    F_MULTU, F_DIVU, F_MFHI, F_MFLO: alu_control = 4'b0000;
`ifdef SIGNED_MD_EN
                    F_MULT, F_DIV: alu_control = 4'b0000;
`endif
                    default: begin
                        alu_control = 4'b1111;
                        illegal     = 1'b1;
                    end
                endcase
            end
            2'b11:   alu_control = 4'b1111;
            default: alu_control = 4'b1111;
        endcase
    end

    // One shift-add (MUL) or restoring-subtract (DIV) step, plus sign-fixed final results
    always_comb begin
        w_add      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                     (r_prod[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
        w_shift    = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
        w_trial    = w_shift - {1'b0, r_a};
        w_prod_nxt = r_prod;
        if (r_state == MUL) begin
            w_prod_nxt = {w_add, r_prod[WIDTH-1:1]};
        end else if (r_state == DIV) begin
            // bit WIDTH of the trial difference is the borrow: restore on borrow
            if (!w_trial[WIDTH]) w_prod_nxt = {w_trial[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};
            else                 w_prod_nxt = {w_shift[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0};
        end else begin
            w_prod_nxt = r_prod;
        end
        w_full = r_neg_q ? -w_prod_nxt : w_prod_nxt;
        if (r_state == MUL) begin
            w_res_hi = w_full[2*WIDTH-1:WIDTH];
            w_res_lo = w_full[WIDTH-1:0];
        end else begin
            w_res_hi = r_neg_r ? -w_prod_nxt[2*WIDTH-1:WIDTH] : w_prod_nxt[2*WIDTH-1:WIDTH];
            w_res_lo = w_full[WIDTH-1:0];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state: accept into MUL/DIV, return to IDLE on the final iteration
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_start && !w_dz_case) w_state_nxt = w_is_mul ? MUL : DIV;
                else                       w_state_nxt = IDLE;
            end
            MUL, DIV: begin
                if (r_cnt == CNT_W'(1)) w_state_nxt = IDLE;
                else                    w_state_nxt = r_state;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath, HI/LO and divide-by-zero pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_a     <= {WIDTH{1'b0}};
            r_prod  <= {(2*WIDTH){1'b0}};
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= {WIDTH{1'b0}};
            r_lo    <= {WIDTH{1'b0}};
            r_dz    <= 1'b0;
        end else begin
            r_dz <= 1'b0;
            if (w_start) begin
                if (w_dz_case) begin
                    r_hi <= rs_val;
                    r_lo <= {WIDTH{1'b1}};
                    r_dz <= 1'b1;
                end else begin
                    r_cnt   <= CNT_W'(WIDTH);
                    r_a     <= w_is_mul ? w_rs_mag : w_rt_mag;
                    r_prod  <= {{WIDTH{1'b0}}, (w_is_mul ? w_rt_mag : w_rs_mag)};
                    r_neg_q <= w_is_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                    r_neg_r <= w_is_signed && rs_val[WIDTH-1];
                end
            end else if (r_state != IDLE) begin
                r_prod <= w_prod_nxt;
                r_cnt  <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_control_md.sv
// Randomised self-checking bench for alu_control_md against an arithmetic reference model.
module tb_alu_control_md;
    localparam int W = 32;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_DIV   = 6'b011010;

    localparam logic [5:0] TF [0:13] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
        6'b101010, 6'b100111, 6'b100110, 6'b000000, 6'b000010, 6'b101011,
        6'b011001, 6'b011011, 6'b010000, 6'b010010};
    localparam logic [3:0] TC [0:13] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
        4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100,
        4'b0000, 4'b0000, 4'b0000, 4'b0000};

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   alu_op;
    logic [5:0]   funct;
    logic         valid;
    logic [W-1:0] rs_val, rt_val;
    logic [3:0]   alu_control;
    logic         illegal, stall, md_busy, div_zero;
    logic [W-1:0] hi, lo;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] m_hi, m_lo;

    alu_control_md #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .alu_op(alu_op), .funct(funct), .valid(valid),
        .rs_val(rs_val), .rt_val(rt_val), .alu_control(alu_control), .illegal(illegal),
        .stall(stall), .md_busy(md_busy), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 5'b0_0010;
        if (op == 2'b01) return (f == 6'b001000) ? 5'b0_0011 : 5'b0_0110;
        if (op == 2'b11) return 5'b0_1111;
        for (int i = 0; i < 14; i++)
            if (TF[i] == f) return {1'b0, TC[i]};
`ifdef SIGNED_MD_EN
        if (f == F_MULT || f == F_DIV) return 5'b0_0000;
`endif
        return 5'b1_1111;
    endfunction

    function automatic void md_ref(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] eh, output logic [W-1:0] el, output bit dz);
        logic [2*W-1:0] p;
        dz = 1'b0;
        eh = '0;
        el = '0;
        if (f == F_MULTU) begin
            p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            eh = p[2*W-1:W];
            el = p[W-1:0];
        end else if (f == F_DIVU || f == F_DIV) begin
            if (b == '0) begin
                eh = a;
                el = '1;
                dz = 1'b1;
            end else if (f == F_DIVU) begin
                el = a / b;
                eh = a % b;
            end else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
                el = a;
                eh = '0;
            end else begin
                el = $signed(a) / $signed(b);
                eh = $signed(a) % $signed(b);
            end
        end else if (f == F_MULT) begin
            p  = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
            eh = p[2*W-1:W];
            el = p[W-1:0];
        end
    endfunction

    task automatic run_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string tag, input bit alt);
        logic [W-1:0] eh, el;
        bit dz;
        int k;
        md_ref(f, a, b, eh, el, dz);
        valid = 1'b1; alu_op = 2'b10; funct = f; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        if (dz) begin
            valid = 1'b0;
            check({tag, "_dz_pulse"}, div_zero, 1);
            check({tag, "_dz_busy"}, md_busy, 0);
            check({tag, "_hi"}, hi, eh);
            check({tag, "_lo"}, lo, el);
            @(posedge clk); #1;
            check({tag, "_dz_clear"}, div_zero, 0);
        end else begin
            check({tag, "_hold_hi"}, hi, m_hi);
            check({tag, "_hold_lo"}, lo, m_lo);
            k = 0;
            while (md_busy === 1'b1 && k < W + 8) begin
                valid = 1'b1; alu_op = 2'b10;
                funct = (alt && (k % 2 == 1)) ? F_ADD : F_MFLO;
                #1;
                check({tag, "_stall"}, stall, (alt && (k % 2 == 1)) ? 0 : 1);
                @(posedge clk); #1;
                k++;
            end
            check({tag, "_busy_cycles"}, k, W);
            valid = 1'b1; alu_op = 2'b10; funct = F_MFLO;
            #1;
            check({tag, "_stall_release"}, stall, 0);
            check({tag, "_hi"}, hi, eh);
            check({tag, "_lo"}, lo, el);
            valid = 1'b0;
        end
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [4:0] ed;
        logic [5:0] rf;
        logic [W-1:0] ra, rb;
        int sel;
        reset = 1'b1; valid = 1'b0; alu_op = 2'b00; funct = 6'b000000;
        rs_val = '0; rt_val = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_busy", md_busy, 0);
        check("rst_stall", stall, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_dz", div_zero, 0);

        for (int i = 0; i < 14; i++) begin
            alu_op = 2'b10; funct = TF[i]; #1;
            check("dec_table_code", alu_control, TC[i]);
            check("dec_table_ill", illegal, 0);
        end
        alu_op = 2'b10; funct = 6'b111111; #1;
        check("dec_ff_code", alu_control, 4'b1111);
        check("dec_ff_ill", illegal, 1);
        alu_op = 2'b01; funct = 6'b001000; #1;
        check("dec_op01_jr", alu_control, 4'b0011);
        alu_op = 2'b10; funct = F_DIV; #1;
`ifdef SIGNED_MD_EN
        check("dec_div_ill", illegal, 0);
`else
        check("dec_div_ill", illegal, 1);
        check("dec_div_code", alu_control, 4'b1111);
        funct = F_MULT; #1;
        check("dec_mult_ill", illegal, 1);
`endif
        for (int i = 0; i < 60; i++) begin
            alu_op = 2'($urandom_range(0, 3));
            funct  = 6'($urandom_range(0, 63));
            #1;
            ed = ref_decode(alu_op, funct);
            check("dec_rand_code", alu_control, ed[3:0]);
            check("dec_rand_ill", illegal, ed[4]);
        end
        @(posedge clk); #1;

        run_md(F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, "multu_max", 1'b0);
        run_md(F_DIVU, 32'd100, 32'd7, "divu_100_7", 1'b0);
        run_md(F_DIVU, 32'h0000_1234, 32'd0, "divu_zero", 1'b0);

        valid = 1'b1; alu_op = 2'b10; funct = F_MULTU; rs_val = 32'd1234567; rt_val = 32'd7654321;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("midrst_busy_before", md_busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_busy", md_busy, 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        m_hi = '0; m_lo = '0;
        run_md(F_MULTU, 32'd3, 32'd5, "multu_3x5", 1'b0);

        for (int i = 0; i < 16; i++) begin
            sel = $urandom_range(0, 3);
            ra  = $urandom();
            rb  = (sel == 3) ? 32'($urandom_range(0, 3)) : $urandom();
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(8, 30);
            rf  = (sel < 2) ? F_MULTU : F_DIVU;
            run_md(rf, ra, rb, "rand_unsigned", 1'b1);
        end

`ifdef SIGNED_MD_EN
        run_md(F_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 1'b0);
        run_md(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_minneg", 1'b0);
        run_md(F_DIV, 32'hFFFF_FFF9, 32'd0, "div_zero", 1'b0);
        run_md(F_MULT, 32'hFFFF_FFFD, 32'd5, "mult_m3_5", 1'b0);
        for (int i = 0; i < 12; i++) begin
            ra = $urandom();
            rb = $urandom() >> $urandom_range(0, 28);
            if ($urandom_range(0, 1) == 1) rb = -rb;
            rf = ($urandom_range(0, 1) == 1) ? F_MULT : F_DIV;
            run_md(rf, ra, rb, "rand_signed", 1'b1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
